// File: rtl/instr_encoder_if.sv
// Request/response bundle for the RV32I instruction encoder.
// master drives requests and out_ready; slave is the encoder.
interface instr_encoder_if #(
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       fmt_sel;
  logic [6:0]       opcode;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [31:0]      imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic             out_err;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, fmt_sel, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    input  in_ready, out_valid, out_instr, out_err, out_count
  );

  modport slave (
    input  in_valid, fmt_sel, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    output in_ready, out_valid, out_instr, out_err, out_count
  );
endinterface

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder: packs decoded fields and a full immediate into an
// instruction word, range-checks the immediate and expands LI into LUI/ADDI.
module instr_encoder #(
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_encoder_if.slave     bus
);

  localparam logic [2:0] FMT_I     = 3'b000;
  localparam logic [2:0] FMT_S     = 3'b001;
  localparam logic [2:0] FMT_B     = 3'b010;
  localparam logic [2:0] FMT_J     = 3'b011;
  localparam logic [2:0] FMT_U     = 3'b100;
  localparam logic [2:0] FMT_SHIFT = 3'b101;
  localparam logic [2:0] FMT_LI    = 3'b110;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_LI_LO = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_instr_q, out_instr_d;
  logic             out_err_q, out_err_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [4:0]       li_rd_q, li_rd_d;
  logic [11:0]      li_lo_q, li_lo_d;

  logic        slot_free_c;
  logic        in_ready_c;
  logic        accept_c;
  logic        i_ok_c, b_ok_c, j_ok_c;
  logic [19:0] li_hi_c;
  logic [31:0] enc_word_c;
  logic        enc_err_c;
  logic        enc_two_c;

  // Immediate fits when all bits above the field's sign bit match it.
  assign i_ok_c = (&bus.imm[31:11]) || !(|bus.imm[31:11]);
  assign b_ok_c = ((&bus.imm[31:12]) || !(|bus.imm[31:12])) && !bus.imm[0];
  assign j_ok_c = ((&bus.imm[31:20]) || !(|bus.imm[31:20])) && !bus.imm[0];

  // Upper LUI part pre-compensates for the sign-extended low ADDI part.
  assign li_hi_c = bus.imm[31:12] + 20'(bus.imm[11]);

  assign slot_free_c = !out_valid_q || bus.out_ready;
  assign in_ready_c  = (state_q == ST_IDLE) && slot_free_c;
  assign accept_c    = bus.in_valid && in_ready_c;

  assign bus.in_ready  = rst_n && in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_err   = out_err_q;
  assign bus.out_count = count_q;

  // Format packing for the request currently presented.
  always_comb begin
    enc_word_c = '0;
    enc_err_c  = 1'b0;
    enc_two_c  = 1'b0;
    case (bus.fmt_sel)
      FMT_I: begin
        enc_word_c = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
        enc_err_c  = !i_ok_c;
      end
      FMT_S: begin
        enc_word_c = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], bus.opcode};
        enc_err_c  = !i_ok_c;
      end
      FMT_B: begin
        enc_word_c = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                      bus.imm[4:1], bus.imm[11], bus.opcode};
        enc_err_c  = !b_ok_c;
      end
      FMT_J: begin
        enc_word_c = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                      bus.rd, bus.opcode};
        enc_err_c  = !j_ok_c;
      end
      FMT_U: begin
        enc_word_c = {bus.imm[31:12], bus.rd, bus.opcode};
        enc_err_c  = |bus.imm[11:0];
      end
      FMT_SHIFT: begin
        enc_word_c = {bus.funct7, bus.imm[4:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
        enc_err_c  = |bus.imm[31:5];
      end
      FMT_LI: begin
        if (i_ok_c) begin
          enc_word_c = {bus.imm[11:0], 5'd0, 3'b000, bus.rd, OP_IMM};
        end else begin
          enc_word_c = {li_hi_c, bus.rd, OP_LUI};
          enc_two_c  = |bus.imm[11:0];
        end
      end
      default: begin
        enc_word_c = '0;
        enc_err_c  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_err_q   <= 1'b0;
      count_q     <= '0;
      li_rd_q     <= '0;
      li_lo_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_err_q   <= out_err_d;
      count_q     <= count_d;
      li_rd_q     <= li_rd_d;
      li_lo_q     <= li_lo_d;
    end
  end

  // Next state: the output slot is refilled in the same cycle it drains.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    out_instr_d = out_instr_q;
    out_err_d   = out_err_q;
    count_d     = count_q;
    li_rd_d     = li_rd_q;
    li_lo_d     = li_lo_q;

    if (out_valid_q && bus.out_ready) begin
      count_d = count_q + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          out_valid_d = 1'b1;
          out_instr_d = enc_word_c;
          out_err_d   = enc_err_c;
          if (enc_two_c) begin
            state_d = ST_LI_LO;
            li_rd_d = bus.rd;
            li_lo_d = bus.imm[11:0];
          end
        end
      end
      ST_LI_LO: begin
        if (slot_free_c) begin
          out_valid_d = 1'b1;
          out_instr_d = {li_lo_q, li_rd_q, 3'b000, li_rd_q, OP_IMM};
          out_err_d   = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
